niosmp_nios2_processor_div_cell: RTL and testbench

//  Iterative radix-2 restoring divider for the Nios II A-stage; inverse companion of the mult cell.

---
 rtl/niosmp_nios2_processor_div_cell.sv | 124 ++++++++++++
 tb/tb_niosmp_nios2_processor_div_cell.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/niosmp_nios2_processor_div_cell.sv
// Iterative radix-2 restoring divider for div/divu: fixed DATA_W+2 cycle latency,
// start/done handshake, kill aborts an in-flight op without touching the held results.
module niosmp_nios2_processor_div_cell #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              A_div_start,
   input  logic              A_div_signed,
   input  logic [DATA_W-1:0] A_div_src1,
   input  logic [DATA_W-1:0] A_div_src2,
   input  logic              A_div_kill,
   output logic              A_div_busy,
   output logic              A_div_done,
   output logic [DATA_W-1:0] A_div_quot,
   output logic [DATA_W-1:0] A_div_rem
);

   localparam int unsigned CW = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIXUP
   } state_t;

   state_t            state, next_state;
   logic [CW-1:0]     count;
   logic              op_signed;
   logic [DATA_W-1:0] src1_r, src2_r;
   logic [DATA_W-1:0] dvd;
   logic [DATA_W-1:0] divisor;
   logic [DATA_W-1:0] rem_p;
   logic              sign_q, sign_r, div0;

   logic              accept;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W-1:0] diff;
   logic              ge;

   assign accept = (state == S_IDLE) && A_div_start && !A_div_kill;
   assign A_div_busy = (state != S_IDLE);

   // The shifted partial remainder is DATA_W+1 bits; when it is >= divisor the
   // difference is below the divisor, so a DATA_W-bit subtract is exact.
   assign rem_sh = {rem_p, dvd[DATA_W-1]};
   assign ge     = (rem_sh >= {1'b0, divisor});
   assign diff   = rem_sh[DATA_W-1:0] - divisor;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (accept) next_state = S_PREP;
         S_PREP:  next_state = S_ITER;
         S_ITER:  if (count == '0) next_state = S_FIXUP;
         S_FIXUP: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (A_div_kill && state != S_IDLE) next_state = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count      <= '0;
         op_signed  <= 1'b0;
         src1_r     <= '0;
         src2_r     <= '0;
         dvd        <= '0;
         divisor    <= '0;
         rem_p      <= '0;
         sign_q     <= 1'b0;
         sign_r     <= 1'b0;
         div0       <= 1'b0;
         A_div_done <= 1'b0;
         A_div_quot <= '0;
         A_div_rem  <= '0;
      end else begin
         A_div_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_signed <= A_div_signed;
                  src1_r    <= A_div_src1;
                  src2_r    <= A_div_src2;
               end
            end
            S_PREP: begin
               dvd     <= (op_signed && src1_r[DATA_W-1]) ? -src1_r : src1_r;
               divisor <= (op_signed && src2_r[DATA_W-1]) ? -src2_r : src2_r;
               sign_q  <= op_signed & (src1_r[DATA_W-1] ^ src2_r[DATA_W-1]);
               sign_r  <= op_signed & src1_r[DATA_W-1];
               div0    <= (src2_r == '0);
               rem_p   <= '0;
               count   <= CW'(DATA_W - 1);
            end
            S_ITER: begin
               rem_p <= ge ? diff : rem_sh[DATA_W-1:0];
               dvd   <= {dvd[DATA_W-2:0], ge};
               count <= count - 1'b1;
            end
            S_FIXUP: begin
               if (!A_div_kill) begin
                  A_div_done <= 1'b1;
                  if (div0) begin
                     A_div_quot <= '1;
                     A_div_rem  <= src1_r;
                  end else begin
                     A_div_quot <= sign_q ? -dvd : dvd;
                     A_div_rem  <= sign_r ? -rem_p : rem_p;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_niosmp_nios2_processor_div_cell.sv
// Self-checking bench for the divider: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_niosmp_nios2_processor_div_cell;

   localparam int unsigned W   = 32;
   localparam int          LAT = W + 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         sgn = 1'b0;
   logic         kill = 1'b0;
   logic [W-1:0] s1 = '0;
   logic [W-1:0] s2 = '0;
   logic         busy, done;
   logic [W-1:0] quot, rem_o;

   int checks = 0;
   int errors = 0;

   niosmp_nios2_processor_div_cell #(.DATA_W(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .A_div_start  (start),
      .A_div_signed (sgn),
      .A_div_src1   (s1),
      .A_div_src2   (s2),
      .A_div_kill   (kill),
      .A_div_busy   (busy),
      .A_div_done   (done),
      .A_div_quot   (quot),
      .A_div_rem    (rem_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division, remainder follows dividend, /0 -> all ones & src1.
   function automatic logic [63:0] model(input bit is_signed, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 0) return {32'hFFFF_FFFF, a};
      if (is_signed) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {q[31:0], r[31:0]};
      end
      return {a / b, a % b};
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input bit is_signed, input logic [W-1:0] a, input logic [W-1:0] b);
      sgn   = is_signed;
      s1    = a;
      s2    = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sgn   = 1'($urandom);
      s1    = $urandom;
      s2    = $urandom;
   endtask

   task automatic wait_done(input string tag, input int n0, input logic [63:0] exp);
      int n = n0;
      int busy_bad = 0;
      while (!done && n < 100) begin
         if (!busy) busy_bad++;
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, n, LAT);
      check({tag, " busy"}, busy_bad, 0);
      check({tag, " quot"}, quot, exp[63:32]);
      check({tag, " rem"}, rem_o, exp[31:0]);
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check({tag, " no done"}, seen, 0);
   endtask

   initial begin
      logic [W-1:0] a, b;
      bit           rs;
      logic [63:0]  e;

      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset quot", quot, 0);
      check("reset rem", rem_o, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      issue(0, 100, 7);
      check("divu busy after start", busy, 1);
      wait_done("divu 100/7", 0, {32'd14, 32'd2});
      @(negedge clk);
      check("done pulse width", done, 0);

      issue(1, 32'hFFFF_FFF9, 2);
      wait_done("div -7/2", 0, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      issue(1, 7, 32'hFFFF_FFFE);
      wait_done("div 7/-2", 0, {32'hFFFF_FFFD, 32'd1});
      issue(1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div ovf", 0, {32'h8000_0000, 32'd0});
      issue(0, 5, 0);
      wait_done("divu 5/0", 0, {32'hFFFF_FFFF, 32'd5});
      issue(1, 32'hFFFF_FFFB, 0);
      wait_done("div -5/0", 0, {32'hFFFF_FFFF, 32'hFFFF_FFFB});

      // start in the done cycle of the previous op
      issue(1, 50, 5);
      check("b2b done cleared", done, 0);
      wait_done("b2b 50/5", 0, {32'd10, 32'd0});
      @(negedge clk);

      issue(0, 9, 3);
      repeat (10) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill busy", busy, 0);
      watch_no_done("kill", 40);
      check("kill quot held", quot, 10);
      check("kill rem held", rem_o, 0);

      issue(0, 200, 7);
      repeat (5) @(negedge clk);
      start = 1'b1;
      s1 = 9;
      s2 = 3;
      @(negedge clk);
      start = 1'b0;
      wait_done("restart ignored", 6, {32'd28, 32'd4});
      @(negedge clk);

      start = 1'b1;
      kill  = 1'b1;
      s1 = 81;
      s2 = 9;
      @(negedge clk);
      start = 1'b0;
      kill  = 1'b0;
      check("kill+start busy", busy, 0);
      watch_no_done("kill+start", 40);
      check("kill+start quot held", quot, 28);

      issue(0, 1000, 3);
      repeat (19) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midop reset busy", busy, 0);
      check("midop reset quot", quot, 0);
      check("midop reset rem", rem_o, 0);
      check("midop reset done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      watch_no_done("after reset", 40);
      check("after reset busy", busy, 0);

      for (int i = 0; i < 150; i++) begin
         rs = 1'($urandom);
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = W'($urandom_range(1, 15));
            2: begin
               a = 32'h8000_0000;
               b = 32'hFFFF_FFFF;
            end
            3: b = b >> $urandom_range(1, 31);
            4: a = a >> $urandom_range(0, 31);
            default: ;
         endcase
         e = model(rs, a, b);
         issue(rs, a, b);
         wait_done($sformatf("rand%0d %s %h/%h", i, rs ? "div" : "divu", a, b), 0, e);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
